div_32bits_seq: RTL and testbench

Sequential 32-bit integer divider for the MIPS pipeline's execute stage, serving DIV and DIVU. It computes quotient and remainder by restoring division, one quotient bit per clock, using a WIDTH+1-bit trial subtraction. Results go to the HI/LO write path: quotient to LO, remainder to HI. The pipeline controller stalls on `busy` and may abort an operation with `cancel` on a flush.

---
 rtl/div_32bits_seq_if.sv | 27 ++
 rtl/div_32bits_seq.sv | 139 +++++++++++++
 tb/tb_div_32bits_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_32bits_seq_if.sv
// Handshake and operand/result bundle between the pipeline controller and the divider.
interface div_32bits_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Pipeline controller side.
    modport master (
        output start, sign, dividend, divisor, cancel,
        input  busy, done, div_zero, quotient, remainder
    );

    // Divider side.
    modport slave (
        input  start, sign, dividend, divisor, cancel,
        output busy, done, div_zero, quotient, remainder
    );
endinterface

// File: rtl/div_32bits_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock, results to HI/LO.
module div_32bits_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    div_32bits_seq_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e            r_state;
    logic              r_sign;
    logic              r_dvd_neg;
    logic              r_dvs_neg;
    logic              r_zero;
    logic [WIDTH-1:0]  r_dvs_mag;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_q;
    logic [CntW-1:0]   r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_div_zero;
    logic [WIDTH-1:0]  r_quotient;
    logic [WIDTH-1:0]  r_remainder;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;
    logic [WIDTH:0]    w_p;
    logic [WIDTH:0]    w_t;
    logic [WIDTH-1:0]  w_q_fix;
    logic [WIDTH-1:0]  w_rem_fix;

    // Operand signs only matter for DIV; the most negative value stays as its unsigned magnitude.
    assign w_dvd_neg = bus.sign & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.sign & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // Trial subtraction, one bit wider so the borrow lands in the MSB.
    assign w_p = {r_rem, r_q[WIDTH-1]};
    assign w_t = w_p - {1'b0, r_dvs_mag};

    // Sign correction of the magnitude results.
    assign w_q_fix   = (r_sign && (r_dvd_neg ^ r_dvs_neg)) ? (~r_q + 1'b1) : r_q;
    assign w_rem_fix = (r_sign && r_dvd_neg) ? (~r_rem + 1'b1) : r_rem;

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sign      <= 1'b0;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            r_zero      <= 1'b0;
            r_dvs_mag   <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start && !bus.cancel) begin
                        r_sign    <= bus.sign;
                        r_dvd_neg <= w_dvd_neg;
                        r_dvs_neg <= w_dvs_neg;
                        r_dvs_mag <= w_dvs_mag;
                        r_q       <= w_dvd_mag;
                        r_cnt     <= CntW'(WIDTH);
                        r_busy    <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Raw dividend parks in rem so FIX can return it as HI.
                            r_zero  <= 1'b1;
                            r_rem   <= bus.dividend;
                            r_state <= StFix;
                        end else begin
                            r_zero  <= 1'b0;
                            r_rem   <= '0;
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (bus.cancel) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        if (!w_t[WIDTH]) begin
                            r_rem <= w_t[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_p[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CntW'(1)) begin
                            r_state <= StFix;
                        end
                    end
                end
                StFix: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    if (!bus.cancel) begin
                        r_done <= 1'b1;
                        if (r_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= r_rem;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_quotient  <= w_q_fix;
                            r_remainder <= w_rem_fix;
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_32bits_seq.sv
// Directed self-checking bench for div_32bits_seq.
module tb_div_32bits_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div_32bits_seq_if #(.WIDTH(32)) bus ();

    div_32bits_seq #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one division, optionally poke a 50/5 start at edge poke_at, then check results.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic sgn, input int poke_at, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, input int elat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.sign     = sgn;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        lat       = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (c == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
            @(posedge clk);
            #1;
            if (c == poke_at) begin
                bus.start    = 1'b0;
                bus.dividend = dvd;
                bus.divisor  = dvs;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) lat = c;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(elat));
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(ez));
    endtask

    initial begin
        int dones;
        n_checks     = 0;
        n_fail       = 0;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.cancel   = 1'b0;
        rst_n        = 1'b0;
        #12;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("100/7u", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 33);
        #10;
        check("hold quotient", bus.quotient, 32'd14);
        check("done one cycle", 32'(bus.done), 32'd0);
        run_op("-7/2s", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op("max/1u", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("-1/1s", 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("div0", 32'h1234_5678, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);

        // Cancel at iteration 10 of a 100/7 run.
        @(negedge clk);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.sign     = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        check("cancel busy", 32'(bus.busy), 32'd0);
        check("cancel done", 32'(bus.done), 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("cancel no done", 32'(dones), 32'd0);
        check("cancel quotient kept", bus.quotient, 32'hFFFF_FFFF);
        check("cancel remainder kept", bus.remainder, 32'h1234_5678);
        check("cancel div_zero kept", 32'(bus.div_zero), 32'd1);

        run_op("9/3u", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0, 33);
        run_op("poke", 32'd100, 32'd7, 1'b0, 4, 32'd14, 32'd2, 1'b0, 33);

        // Reset at iteration 5.
        @(negedge clk);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset quotient", bus.quotient, 32'd0);
        check("midreset remainder", bus.remainder, 32'd0);
        check("midreset div_zero", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 32'd50, 32'd5, 1'b0, 0, 32'd10, 32'd0, 1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
